// File: rtl/image_frame_loader.sv
// image_frame_loader: loads one NUM_PIXELS-byte frame into image RAM, starts inference, latches the result.
// Define SYNC_HDR_EN to require a 0xAA,0x55 header before every frame.
module image_frame_loader #(
    parameter int NUM_PIXELS     = 784,
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int TO_W           = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic [ADDR_W-1:0] img_wr_addr_o,
    output logic [7:0]        img_wr_data_o,
    output logic              img_wr_en_o,
    output logic              inf_start_o,
    input  logic              inf_done_i,
    input  logic [3:0]        inf_digit_i,
    output logic              busy_o,
    output logic [3:0]        result_digit_o,
    output logic              result_valid_o,
    output logic              frame_err_o
);
`ifdef SYNC_HDR_EN
    typedef enum logic [2:0] {HDR0, HDR1, LOAD, START, WAIT_DONE} state_t;
    localparam state_t ARM = HDR0;
`else
    typedef enum logic [1:0] {LOAD, START, WAIT_DONE} state_t;
    localparam state_t ARM = LOAD;
`endif

    state_t              state_q;
    logic [ADDR_W-1:0]   pix_cnt_q;
    logic [TO_W-1:0]     gap_q, gap_d;
    logic                rx_ready_q, img_wr_en_q, inf_start_q, busy_q, result_valid_q, frame_err_q;
    logic [ADDR_W-1:0]   img_wr_addr_q;
    logic [7:0]          img_wr_data_q;
    logic [3:0]          result_digit_q;
    logic                accept, last_pix, timeout;

    always_comb begin
        accept   = rx_valid_i & rx_ready_q;
        last_pix = pix_cnt_q == ADDR_W'(NUM_PIXELS - 1);
        gap_d    = gap_q + 1'b1;
        timeout  = gap_d == TO_W'(TIMEOUT_CYCLES);
    end

    // rx_ready is registered, so it must already reflect the state entered at this edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ARM;
            pix_cnt_q      <= '0;
            gap_q          <= '0;
            rx_ready_q     <= 1'b0;
            img_wr_en_q    <= 1'b0;
            img_wr_addr_q  <= '0;
            img_wr_data_q  <= '0;
            inf_start_q    <= 1'b0;
            busy_q         <= 1'b0;
            result_digit_q <= '0;
            result_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            rx_ready_q  <= 1'b1;
            img_wr_en_q <= 1'b0;
            inf_start_q <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
`ifdef SYNC_HDR_EN
                HDR0: if (accept && rx_data_i == 8'hAA) state_q <= HDR1;
                HDR1: if (accept) state_q <= rx_data_i == 8'h55 ? LOAD : rx_data_i == 8'hAA ? HDR1 : HDR0;
`endif
                LOAD: begin
                    if (accept) begin
                        img_wr_en_q   <= 1'b1;
                        img_wr_addr_q <= pix_cnt_q;
                        img_wr_data_q <= rx_data_i;
                        gap_q         <= '0;
                        if (pix_cnt_q == '0) begin
                            busy_q         <= 1'b1;
                            result_valid_q <= 1'b0;
                        end
                        if (last_pix) begin
                            pix_cnt_q  <= '0;
                            rx_ready_q <= 1'b0;
                            state_q    <= START;
                        end else begin
                            pix_cnt_q <= pix_cnt_q + 1'b1;
                        end
                    end else if (pix_cnt_q != '0) begin
                        if (timeout) begin
                            frame_err_q <= 1'b1;
                            pix_cnt_q   <= '0;
                            gap_q       <= '0;
                            busy_q      <= 1'b0;
                            state_q     <= ARM;
                        end else begin
                            gap_q <= gap_d;
                        end
                    end
                end
                START: begin
                    inf_start_q <= 1'b1;
                    rx_ready_q  <= 1'b0;
                    state_q     <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    rx_ready_q <= inf_done_i;
                    if (inf_done_i) begin
                        result_digit_q <= inf_digit_i;
                        result_valid_q <= 1'b1;
                        busy_q         <= 1'b0;
                        state_q        <= ARM;
                    end
                end
                default: state_q <= ARM;
            endcase
        end
    end

    assign rx_ready_o     = rx_ready_q;
    assign img_wr_en_o    = img_wr_en_q;
    assign img_wr_addr_o  = img_wr_addr_q;
    assign img_wr_data_o  = img_wr_data_q;
    assign inf_start_o    = inf_start_q;
    assign busy_o         = busy_q;
    assign result_digit_o = result_digit_q;
    assign result_valid_o = result_valid_q;
    assign frame_err_o    = frame_err_q;
endmodule

// File: tb/tb_image_frame_loader.sv
// tb_image_frame_loader: directed bench for image_frame_loader with a shortened timeout.
// Honours SYNC_HDR_EN by prefixing each frame with 0x12,0xAA,0xAA,0x55.
module tb_image_frame_loader;
    localparam int NP = 784;
    localparam int TO = 50;

    logic       clk = 1'b0, rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0, inf_done = 1'b0;
    logic [3:0] inf_digit = 4'h0;
    logic       rx_ready, img_wr_en, inf_start, busy, result_valid, frame_err;
    logic [9:0] img_wr_addr;
    logic [7:0] img_wr_data;
    logic [3:0] result_digit;

    image_frame_loader #(.NUM_PIXELS(NP), .ADDR_W(10), .TIMEOUT_CYCLES(TO), .TO_W(20)) dut (
        .clk(clk), .rst(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
        .img_wr_addr_o(img_wr_addr), .img_wr_data_o(img_wr_data), .img_wr_en_o(img_wr_en),
        .inf_start_o(inf_start), .inf_done_i(inf_done), .inf_digit_i(inf_digit), .busy_o(busy),
        .result_digit_o(result_digit), .result_valid_o(result_valid), .frame_err_o(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, stalls = 0, cyc = 0;
    int wr_cnt = 0, start_cnt = 0, err_cnt = 0, seq_err = 0, exp_addr = 0;
    int last_wr_cyc = 0, start_cyc = 0;
    logic [7:0] mem [NP];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin : mon
        int a;
        a = int'(img_wr_addr);
        if (rst) exp_addr = 0;
        if (img_wr_en) begin
            if (a != exp_addr) seq_err++;
            if (a < NP) mem[a] = img_wr_data;
            exp_addr = (a == NP - 1) ? 0 : a + 1;
            wr_cnt++;
            last_wr_cyc = cyc;
        end
        if (inf_start) begin
            start_cnt++;
            start_cyc = cyc;
        end
        if (frame_err) begin
            err_cnt++;
            exp_addr = 0;
        end
    end

    function automatic logic [7:0] pix(input int kind, input int k);
        logic [31:0] v;
        v = (kind == 0) ? k : (kind == 1) ? k * 3 + 1 : k ^ 32'h5A;
        return v[7:0];
    endfunction

    function automatic int bad_pix(input int kind);
        int b = 0;
        for (int k = 0; k < NP; k++) if (mem[k] !== pix(kind, k)) b++;
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 100) begin
            tick();
            n++;
        end
        if (!rx_ready) stalls++;
        tick();
    endtask

    task automatic send_hdr();
`ifdef SYNC_HDR_EN
        send_byte(8'h12);
        send_byte(8'hAA);
        send_byte(8'hAA);
        send_byte(8'h55);
`endif
    endtask

    task automatic send_pix(input int kind, input int from, input int upto);
        for (int k = from; k < upto; k++) send_byte(pix(kind, k));
    endtask

    task automatic finish_inf(input logic [3:0] d);
        int n = 0;
        rx_valid = 1'b0;
        while (!inf_start && n < 50) begin
            tick();
            n++;
        end
        if (!inf_start) stalls++;
        repeat (4) tick();
        inf_done = 1'b1;
        inf_digit = d;
        tick();
        inf_done = 1'b0;
    endtask

    initial begin
        int w0, s0, e0, hw;
        // reset state
        tick();
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_en", img_wr_en, 0);
        chk("rst_start", inf_start, 0);
        chk("rst_result", {result_valid, result_digit, frame_err}, 0);
        rst = 1'b0;
        tick();
        chk("arm_rx_ready", rx_ready, 1);

        // full frame, result, bytes held off during inference
        w0 = wr_cnt; s0 = start_cnt;
        send_hdr();
        hw = wr_cnt;
        chk("hdr_no_write", hw - w0, 0);
        send_pix(0, 0, 1);
        chk("p0_wr", {img_wr_en, img_wr_addr, img_wr_data}, {1'b1, 10'd0, 8'h00});
        chk("p0_busy", {busy, result_valid}, 2'b10);
        send_pix(0, 1, NP);
        chk("last_wr", {img_wr_en, img_wr_addr, img_wr_data}, {1'b1, 10'd783, 8'h0F});
        chk("last_ready", {rx_ready, inf_start}, 2'b00);
        rx_data = 8'hEE;
        rx_valid = 1'b1;
        tick();
        chk("start_pulse", {inf_start, img_wr_en, rx_ready}, 3'b100);
        repeat (4) tick();
        chk("wait_hold", {inf_start, img_wr_en, rx_ready, busy}, 4'b0001);
        inf_done = 1'b1;
        inf_digit = 4'd7;
        rx_valid = 1'b0;
        tick();
        inf_done = 1'b0;
        chk("res1", {result_valid, result_digit, busy, rx_ready}, {1'b1, 4'd7, 1'b0, 1'b1});
        chk("f1_writes", wr_cnt - w0, NP);
        chk("f1_starts", start_cnt - s0, 1);
        chk("f1_start_lat", start_cyc - last_wr_cyc, 1);
        chk("f1_data", bad_pix(0), 0);
        chk("f1_seq", seq_err, 0);

        // gap timeout, with an accept landing exactly on the timeout cycle
        w0 = wr_cnt; e0 = err_cnt;
        send_hdr();
        send_pix(1, 0, 90);
        rx_valid = 1'b0;
        repeat (TO - 1) tick();
        send_pix(1, 90, 100);
        chk("accept_wins", err_cnt - e0, 0);
        chk("accept_wr", {img_wr_en, img_wr_addr}, {1'b1, 10'd99});
        rx_valid = 1'b0;
        repeat (TO - 1) tick();
        chk("gap49", {frame_err, busy}, 2'b01);
        tick();
        chk("gap50", {frame_err, busy, rx_ready}, 3'b101);
        tick();
        chk("gap51", frame_err, 0);
        chk("to_pulses", err_cnt - e0, 1);
        chk("to_writes", wr_cnt - w0, 100);
        w0 = wr_cnt; s0 = start_cnt;
        send_hdr();
        send_pix(2, 0, NP);
        finish_inf(4'd3);
        chk("f2_writes", wr_cnt - w0, NP);
        chk("f2_data", bad_pix(2), 0);
        chk("f2_seq", seq_err, 0);
        chk("f2_starts", start_cnt - s0, 1);
        chk("res2", {result_valid, result_digit}, {1'b1, 4'd3});

        // reset mid-frame
        send_hdr();
        send_pix(1, 0, 1);
        chk("p0_clear_valid", {busy, result_valid}, 2'b10);
        send_pix(1, 1, 400);
        chk("mid_wr", {img_wr_en, img_wr_addr}, {1'b1, 10'd399});
        #2 rst = 1'b1;
        rx_valid = 1'b0;
        #1;
        chk("async_rst", {rx_ready, img_wr_en, img_wr_addr, img_wr_data, inf_start, busy}, 0);
        chk("async_rst_res", {result_valid, result_digit, frame_err}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        w0 = wr_cnt; s0 = start_cnt; e0 = err_cnt;
        send_hdr();
        send_pix(0, 0, NP);
        finish_inf(4'd9);
        chk("f3_writes", wr_cnt - w0, NP);
        chk("f3_data", bad_pix(0), 0);
        chk("f3_seq", seq_err, 0);
        chk("f3_starts", start_cnt - s0, 1);
        chk("f3_no_err", err_cnt - e0, 0);
        chk("res3", {result_valid, result_digit, busy}, {1'b1, 4'd9, 1'b0});
        chk("no_stall", stalls, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
